// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding request to a variable-latency imem,
// a single-entry hold buffer for decode stalls, and drop tracking for redirects.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    input  logic            id_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            fetch_stall,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;

    logic            can_accept;
    logic            deliver;
    logic [XLEN-1:0] deliver_instr;
    logic [XLEN-1:0] deliver_pc;

    assign can_accept = !id_stall || !if_id_valid_q;
    assign imem_addr  = pc_in;

    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        req_pc_d      = req_pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        imem_req      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_pc    = req_pc_q;

        case (state_q)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    req_pc_d = pc_in;
                    state_d  = S_WAIT;
                    // A grant in a redirect cycle fetched the old path.
                    if (flush) begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (can_accept) begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = req_pc_q;
                        state_d      = S_HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                deliver_instr = hold_instr_q;
                deliver_pc    = hold_pc_q;
                if (flush) begin
                    state_d = S_REQ;
                end else if (can_accept) begin
                    deliver = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if (flush || (!deliver && !id_stall)) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (deliver) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = deliver_instr;
            if_id_pc_d    = deliver_pc;
        end

        // PC advances together with an IF/ID load, or to take a redirect.
        fetch_stall = rst || !(deliver || flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            drop_q        <= 1'b0;
            req_pc_q      <= '0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            req_pc_q      <= req_pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
        end
    end

    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: the bench plays the imem and PC register
// cycle by cycle and checks outputs against hand-computed values.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic        flush = 1'b0;
    logic        id_stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        fetch_stall;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.XLEN(32), .NOP_INSTR(32'h00000013)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .flush      (flush),
        .id_stall   (id_stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .fetch_stall(fetch_stall),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        flush = 1'b0; id_stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1; pc_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        settle();
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall_in_reset: got %0b want 1", fetch_stall); end
        tick();
        rst = 1'b0;
        settle();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0b want 0", if_id_valid); end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("[TB] FAIL rst_instr: got %h want %h", if_id_instr, NOP); end
        checks++; if (if_id_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h want 0", if_id_pc); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_req: got %0b want 1", imem_req); end
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall: got %0b want 1", fetch_stall); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] instrs [3];
        instrs[0] = 32'h11110000; instrs[1] = 32'h22220004; instrs[2] = 32'h33330008;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(4 * i); imem_gnt = 1'b1; imem_rvalid = 1'b0;
            settle();
            checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL zw_req[%0d]: got %0b want 1", i, imem_req); end
            checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("[TB] FAIL zw_addr[%0d]: got %h want %h", i, imem_addr, 4 * i); end
            checks++; if (fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL zw_stall_req[%0d]: got %0b want 1", i, fetch_stall); end
            if (i > 0) begin
                checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * (i - 1)) || if_id_instr !== instrs[i-1]) begin
                    errors++; $display("[TB] FAIL zw_ifid[%0d]: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", i, if_id_valid, if_id_pc, if_id_instr, 4 * (i - 1), instrs[i-1]);
                end
            end
            tick();
            imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instrs[i];
            settle();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL zw_req_wait[%0d]: got %0b want 0", i, imem_req); end
            checks++; if (fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL zw_stall_rvalid[%0d]: got %0b want 0", i, fetch_stall); end
            checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL zw_bubble[%0d]: got %0b want 0", i, if_id_valid); end
            tick();
        end
        clear_inputs(); pc_in = 32'hC;
        settle();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== instrs[2]) begin
            errors++; $display("[TB] FAIL zw_last: got v=%0b pc=%h instr=%h want v=1 pc=8 instr=%h", if_id_valid, if_id_pc, if_id_instr, instrs[2]);
        end
    endtask

    task automatic test_slow_mem();
        do_reset();
        pc_in = 32'h0;
        for (int c = 0; c < 4; c++) begin
            imem_gnt = (c == 3);
            settle();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL slow_req[%0d]: got req=%0b addr=%h want req=1 addr=0", c, imem_req, imem_addr); end
            checks++; if (fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL slow_stall_req[%0d]: got %0b want 1", c, fetch_stall); end
            tick();
        end
        imem_gnt = 1'b0;
        settle();
        checks++; if (imem_req !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL slow_wait: got req=%0b stall=%0b want req=0 stall=1", imem_req, fetch_stall); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hCAFE0000;
        settle();
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL slow_stall_rvalid: got %0b want 0", fetch_stall); end
        tick();
        imem_rvalid = 1'b0; pc_in = 32'h4;
        settle();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'hCAFE0000) begin
            errors++; $display("[TB] FAIL slow_ifid: got v=%0b pc=%h instr=%h want v=1 pc=0 instr=cafe0000", if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    // Leaves the DUT in HOLD with IF/ID = {pc 0x4, 0xAAAA0004} and 0x8 buffered.
    task automatic enter_hold();
        do_reset();
        pc_in = 32'h4; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA0004;
        tick();
        imem_rvalid = 1'b0; pc_in = 32'h8; id_stall = 1'b1; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        settle();
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_stall_rvalid: got %0b want 1", fetch_stall); end
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_decode_stall();
        enter_hold();
        settle();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || if_id_instr !== 32'hAAAA0004) begin
            errors++; $display("[TB] FAIL ds_ifid_held: got v=%0b pc=%h instr=%h want v=1 pc=4 instr=aaaa0004", if_id_valid, if_id_pc, if_id_instr);
        end
        checks++; if (fetch_stall !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL ds_hold_outs: got stall=%0b req=%0b want stall=1 req=0", fetch_stall, imem_req); end
        tick();
        id_stall = 1'b0;
        settle();
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL ds_stall_deliver: got %0b want 0", fetch_stall); end
        tick();
        pc_in = 32'hC;
        settle();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_instr !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL ds_ifid_release: got v=%0b pc=%h instr=%h want v=1 pc=8 instr=deadbeef", if_id_valid, if_id_pc, if_id_instr);
        end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ds_req_after: got %0b want 1", imem_req); end
    endtask

    // Shared tail: fetch from the redirect target and check it lands in IF/ID.
    task automatic fetch_target(input logic [31:0] target, input logic [31:0] instr, input string name);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr;
        tick();
        imem_rvalid = 1'b0;
        settle();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== target || if_id_instr !== instr) begin
            errors++; $display("[TB] FAIL %s_target: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", name, if_id_valid, if_id_pc, if_id_instr, target, instr);
        end
    endtask

    task automatic test_flush_wait();
        do_reset();
        pc_in = 32'h10; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; flush = 1'b1;
        settle();
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL fw_stall_flush: got %0b want 0", fetch_stall); end
        tick();
        flush = 1'b0; pc_in = 32'h100; imem_rvalid = 1'b1; imem_rdata = 32'hBAD00010;
        settle();
        checks++; if (imem_req !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL fw_drop_cycle: got req=%0b stall=%0b want req=0 stall=1", imem_req, fetch_stall); end
        tick();
        imem_rvalid = 1'b0;
        settle();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL fw_discard: got valid=%0b want 0", if_id_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL fw_next_addr: got req=%0b addr=%h want req=1 addr=100", imem_req, imem_addr); end
        fetch_target(32'h100, 32'h600D0100, "fw");
    endtask

    task automatic test_flush_rvalid();
        do_reset();
        pc_in = 32'h20; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD00020; flush = 1'b1;
        settle();
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL fr_stall: got %0b want 0", fetch_stall); end
        tick();
        imem_rvalid = 1'b0; flush = 1'b0; pc_in = 32'h200;
        settle();
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("[TB] FAIL fr_no_load: got v=%0b instr=%h want v=0 instr=%h", if_id_valid, if_id_instr, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL fr_next_addr: got req=%0b addr=%h want req=1 addr=200", imem_req, imem_addr); end
        fetch_target(32'h200, 32'h600D0200, "fr");
    endtask

    task automatic test_flush_gnt();
        do_reset();
        pc_in = 32'h30; imem_gnt = 1'b1; flush = 1'b1;
        settle();
        checks++; if (fetch_stall !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL fg_flush_cycle: got stall=%0b req=%0b want stall=0 req=1", fetch_stall, imem_req); end
        tick();
        imem_gnt = 1'b0; flush = 1'b0; pc_in = 32'h300;
        settle();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL fg_wait_req: got %0b want 0", imem_req); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD00030;
        settle();
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL fg_drop_stall: got %0b want 1", fetch_stall); end
        tick();
        imem_rvalid = 1'b0;
        settle();
        checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++; $display("[TB] FAIL fg_after_drop: got v=%0b req=%0b addr=%h want v=0 req=1 addr=300", if_id_valid, imem_req, imem_addr);
        end
        fetch_target(32'h300, 32'h600D0300, "fg");
    endtask

    task automatic test_reset_in_hold();
        enter_hold();
        rst = 1'b1;
        settle();
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL rh_stall_in_reset: got %0b want 1", fetch_stall); end
        tick();
        rst = 1'b0; id_stall = 1'b0;
        settle();
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("[TB] FAIL rh_ifid: got v=%0b instr=%h want v=0 instr=%h", if_id_valid, if_id_instr, NOP); end
        checks++; if (fetch_stall !== 1'b1 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rh_outs: got stall=%0b req=%0b want stall=1 req=1", fetch_stall, imem_req); end
        tick();
        settle();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rh_buffer_gone: got %0b want 0", if_id_valid); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        pc_in = 32'h40; imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin errors++; $display("[TB] FAIL rw_ifid: got v=%0b instr=%h want v=0 instr=%h", if_id_valid, if_id_instr, NOP); end
        checks++; if (fetch_stall !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++; $display("[TB] FAIL rw_outs: got stall=%0b req=%0b addr=%h want stall=1 req=1 addr=40", fetch_stall, imem_req, imem_addr);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_zero_wait();
        test_slow_mem();
        test_decode_stall();
        test_flush_wait();
        test_flush_rvalid();
        test_flush_gnt();
        test_reset_in_hold();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register; consumes its current PC and feeds the IF/ID pipeline register.
- Issues one request at a time to an instruction memory with variable latency (req/gnt, rvalid).
- Buffers one returned instruction when decode is stalled, and discards in-flight fetches on a redirect.
- Drives fetch_stall, which is OR'd into the PC register's Stall input.

Parameters:
- XLEN, 32, address/instruction width.
- NOP_INSTR, 32'h00000013, instruction word driven on if_id_instr when a bubble is inserted.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  XLEN  current PC from the PC register.
- flush  in  1  redirect (PCSrc != 00) this cycle; kill IF/ID and any in-flight fetch.
- id_stall  in  1  decode cannot consume IF/ID this cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address, equal to pc_in while imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; at most one per granted request, never in the grant cycle.
- imem_rdata  in  XLEN  response instruction.
- fetch_stall  out  1  hold the PC register.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  XLEN  IF/ID instruction.
- if_id_pc  out  XLEN  PC of if_id_instr.

Behaviour:
- Reset (rst=1 at an edge), regardless of state or in-flight request:
  - state<=REQ, drop<=0, if_id_valid<=0, if_id_instr<=NOP_INSTR, if_id_pc<=0, hold buffer invalid.
  - A response arriving after reset for a pre-reset request is a memory-side error; it is not required to be handled.
- can_accept = !id_stall || !if_id_valid.
- States:
  - REQ:
    - imem_req=1, imem_addr=pc_in.
    - On imem_gnt: req_pc<=pc_in, go to WAIT.
    - If flush=1 in the same cycle as gnt: drop<=1, because the granted address is the old path.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid with drop=1: discard the response, drop<=0, go to REQ.
    - On imem_rvalid with drop=0 and can_accept: deliver the response to IF/ID and go to REQ.
    - On imem_rvalid with drop=0 and !can_accept: store {imem_rdata, req_pc} in the hold buffer and go to HOLD.
  - HOLD:
    - imem_req=0.
    - When can_accept: deliver from the hold buffer and go to REQ.
- Deliver means if_id_valid<=1, if_id_instr<=instr, if_id_pc<=its PC. Latency from rvalid to if_id_valid is 1 cycle when there is no stall.
- IF/ID when not delivering:
  - id_stall=1: hold IF/ID contents.
  - id_stall=0: bubble, i.e. if_id_valid<=0 and if_id_instr<=NOP_INSTR.
- fetch_stall:
  - 0 in a delivering cycle, so the PC advances at the same edge that IF/ID loads.
  - 0 whenever flush=1, so the PC register can load the redirect target.
  - 1 otherwise, including reset cycles.
- Flush has priority over delivery and over id_stall:
  - Always: if_id_valid<=0, if_id_instr<=NOP_INSTR.
  - REQ without gnt: stay in REQ; the next cycle requests the new pc_in.
  - REQ with gnt: go to WAIT with drop<=1.
  - WAIT without rvalid: drop<=1.
  - WAIT with rvalid: discard the response, go to REQ, drop<=0.
  - HOLD: discard the hold buffer, go to REQ.
- A flush while drop is already 1 leaves drop=1; at most one request is ever outstanding.
- Arithmetic: none; addresses are passed through unmodified. pc_in alignment is the PC register's responsibility.

Test Plan:
- Zero-wait memory: after reset, rst=0, gnt same cycle as req, rvalid 1 cycle later, id_stall=0.
  - IF/ID shows pc 0x0, 0x4, 0x8 with matching rdata, one instruction every 2 cycles.
  - fetch_stall=0 only in the rvalid cycles.
- Slow memory: gnt delayed 3 cycles, rvalid delayed 2 more.
  - imem_addr stays 0x0 throughout.
  - fetch_stall=1 until the rvalid cycle.
  - if_id_pc=0x0 one cycle after rvalid.
- Decode stall: if_id_valid=1 with pc 0x4, id_stall=1 when rvalid for pc 0x8 (instr 0xDEADBEEF) arrives.
  - FSM enters HOLD; IF/ID stays at 0x4; fetch_stall=1.
  - After id_stall drops: if_id_pc=0x8, if_id_instr=0xDEADBEEF.
- Flush in WAIT: request for 0x10 granted, flush=1 before rvalid, pc_in becomes 0x100.
  - The 0x10 response is discarded; if_id_valid=0.
  - fetch_stall=0 in the flush cycle.
  - The next imem_addr is 0x100.
- Flush coincident with rvalid and with gnt (two separate runs): no IF/ID load of the old-path instruction; the next delivered if_id_pc equals the redirect target.
- Reset in HOLD and in WAIT: one-cycle rst=1 → if_id_valid=0, if_id_instr=0x00000013, fetch_stall=1, imem_req=1 on the first cycle after reset.
